// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard sequencer.
// State enum, register-index type, x0 and default timeout.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t    X0          = 5'd0;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned WAIT_W      = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating incrementer with enable; holds at all-ones.
// Ports: clk, rst (sync, high), en, q[W-1:0].
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, branch flush, dmem wait.
// Ports: hazard inputs, stall/flush/dmem_req/abort outs, counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Mem_Read_ID_EX,
  input  reg_idx_t         rd_ID_EX,
  input  reg_idx_t         rs1_IF_ID,
  input  reg_idx_t         rs2_IF_ID,
  input  logic             Mem_Read_EX_MEM,
  input  logic             Mem_Write_EX_MEM,
  input  logic             PcSrc_EX_MEM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             mem_abort,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam logic [WAIT_W-1:0] WC_LAST =
    WAIT_W'(TIMEOUT - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_op;
  logic timeout_hit;
  logic busy;
  logic load_use;
  logic sel_mem;
  logic sel_br;
  logic sel_lu;

  assign mem_op = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign dmem_req = mem_op;

  assign timeout_hit = (state == MEM_WAIT) &&
                       (wait_cnt == WC_LAST);

  assign busy = mem_op & ~dmem_ready & ~timeout_hit;

  // Abort only matters while an access is still pending;
  // a reset cycle never produces one.
  assign mem_abort = timeout_hit & mem_op &
                     ~dmem_ready & ~rst;

  assign load_use = Mem_Read_ID_EX &&
                    (rd_ID_EX != X0) &&
                    ((rd_ID_EX == rs1_IF_ID) ||
                     (rd_ID_EX == rs2_IF_ID));

  // One-hot priority selects: wait > branch > load-use.
  assign sel_mem = busy;
  assign sel_br  = ~busy & PcSrc_EX_MEM;
  assign sel_lu  = ~busy & ~PcSrc_EX_MEM & load_use;

  always_comb begin
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    unique case (1'b1)
      sel_mem: begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        stall_EX_MEM = 1'b1;
      end
      sel_br: begin
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
        flush_EX_MEM = 1'b1;
      end
      sel_lu: begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (mem_abort) begin
        mem_err <= 1'b1;
      end
      unique case (state)
        RUN: begin
          if (busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (busy) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk (clk),
    .rst (rst),
    .en  (stall_PC),
    .q   (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk (clk),
    .rst (rst),
    .en  (flush_IF_ID),
    .q   (cnt_flush)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// TIMEOUT=4, CNT_W=2 so timeout and saturation are reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] CMAX = '1;

  // {req, sPC, sIF, sID, sEX, fIF, fID, fEX, abort}
  localparam logic [8:0] NONE  = 9'b0_0000_000_0;
  localparam logic [8:0] LU    = 9'b0_1100_010_0;
  localparam logic [8:0] BR    = 9'b0_0000_111_0;
  localparam logic [8:0] MST   = 9'b1_1111_000_0;
  localparam logic [8:0] MREL  = 9'b1_0000_000_0;
  localparam logic [8:0] MRELB = 9'b1_0000_111_0;
  localparam logic [8:0] ABRT  = 9'b1_0000_000_1;

  // ctl = {rst, mr_idex, mr_exmem, mw_exmem, pcsrc, ready}
  localparam logic [5:0] C_RST = 6'b100000;
  localparam logic [5:0] C_IDL = 6'b000000;
  localparam logic [5:0] C_LD  = 6'b010000;
  localparam logic [5:0] C_BR  = 6'b000010;
  localparam logic [5:0] C_BLD = 6'b010010;
  localparam logic [5:0] C_RW  = 6'b001000;
  localparam logic [5:0] C_RR  = 6'b001001;
  localparam logic [5:0] C_WW  = 6'b000100;
  localparam logic [5:0] C_COL = 6'b011010;
  localparam logic [5:0] C_COR = 6'b011011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Mem_Read_ID_EX = 1'b0;
  logic [4:0] rd_ID_EX = '0;
  logic [4:0] rs1_IF_ID = '0;
  logic [4:0] rs2_IF_ID = '0;
  logic Mem_Read_EX_MEM = 1'b0;
  logic Mem_Write_EX_MEM = 1'b0;
  logic PcSrc_EX_MEM = 1'b0;
  logic dmem_ready = 1'b0;
  logic dmem_req;
  logic stall_PC, stall_IF_ID;
  logic stall_ID_EX, stall_EX_MEM;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM;
  logic mem_abort, mem_err;
  logic [CW-1:0] cnt_stall, cnt_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Mem_Read_ID_EX   (Mem_Read_ID_EX),
    .rd_ID_EX         (rd_ID_EX),
    .rs1_IF_ID        (rs1_IF_ID),
    .rs2_IF_ID        (rs2_IF_ID),
    .Mem_Read_EX_MEM  (Mem_Read_EX_MEM),
    .Mem_Write_EX_MEM (Mem_Write_EX_MEM),
    .PcSrc_EX_MEM     (PcSrc_EX_MEM),
    .dmem_ready       (dmem_ready),
    .dmem_req         (dmem_req),
    .stall_PC         (stall_PC),
    .stall_IF_ID      (stall_IF_ID),
    .stall_ID_EX      (stall_ID_EX),
    .stall_EX_MEM     (stall_EX_MEM),
    .flush_IF_ID      (flush_IF_ID),
    .flush_ID_EX      (flush_ID_EX),
    .flush_EX_MEM     (flush_EX_MEM),
    .mem_abort        (mem_abort),
    .mem_err          (mem_err),
    .cnt_stall        (cnt_stall),
    .cnt_flush        (cnt_flush)
  );

  typedef struct {
    string         nm;
    logic [8:0]    o;
    logic [CW-1:0] cs;
    logic [CW-1:0] cf;
    logic          err;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] m_cs = '0;
  logic [CW-1:0] m_cf = '0;
  logic          m_err = 1'b0;

  task automatic drive(input string nm,
                       input logic [5:0] ctl,
                       input logic [4:0] rd,
                       input logic [4:0] r1,
                       input logic [4:0] r2,
                       input logic [8:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = ctl[5];
    Mem_Read_ID_EX   = ctl[4];
    Mem_Read_EX_MEM  = ctl[3];
    Mem_Write_EX_MEM = ctl[2];
    PcSrc_EX_MEM     = ctl[1];
    dmem_ready       = ctl[0];
    rd_ID_EX         = rd;
    rs1_IF_ID        = r1;
    rs2_IF_ID        = r2;
    e.nm  = nm;
    e.o   = ex;
    e.cs  = m_cs;
    e.cf  = m_cf;
    e.err = m_err;
    q.push_back(e);
    if (ctl[5]) begin
      m_cs  = '0;
      m_cf  = '0;
      m_err = 1'b0;
    end else begin
      if (ex[7] && m_cs != CMAX) m_cs = m_cs + 1'b1;
      if (ex[3] && m_cf != CMAX) m_cf = m_cf + 1'b1;
      if (ex[0]) m_err = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {dmem_req, stall_PC, stall_IF_ID,
               stall_ID_EX, stall_EX_MEM,
               flush_IF_ID, flush_ID_EX,
               flush_EX_MEM, mem_abort};
        n_tests++;
        if (got !== e.o) begin
          n_fail++;
          $display("FAIL %s ctl got=%b want=%b",
                   e.nm, got, e.o);
        end
        n_tests++;
        if (cnt_stall !== e.cs) begin
          n_fail++;
          $display("FAIL %s cnt_stall got=%0d want=%0d",
                   e.nm, cnt_stall, e.cs);
        end
        n_tests++;
        if (cnt_flush !== e.cf) begin
          n_fail++;
          $display("FAIL %s cnt_flush got=%0d want=%0d",
                   e.nm, cnt_flush, e.cf);
        end
        n_tests++;
        if (mem_err !== e.err) begin
          n_fail++;
          $display("FAIL %s mem_err got=%b want=%b",
                   e.nm, mem_err, e.err);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    repeat (2) @(posedge clk);
    drive("rst_state", C_IDL, 0, 0, 0, NONE);
    drive("idle",      C_IDL, 0, 0, 0, NONE);
    drive("lu_rs2",    C_LD,  5, 3, 5, LU);
    drive("after_lu",  C_IDL, 0, 0, 0, NONE);
    drive("lu_x0",     C_LD,  0, 0, 0, NONE);
    drive("lu_rs1",    C_LD,  7, 7, 2, LU);
    drive("no_load",   C_IDL, 7, 7, 7, NONE);
    drive("lu_nomat",  C_LD,  9, 8, 10, NONE);
    drive("branch",    C_BR,  0, 0, 0, BR);
    drive("br_lu",     C_BLD, 5, 0, 5, BR);
    drive("idle2",     C_IDL, 0, 0, 0, NONE);
    // three wait cycles, release on the fourth
    drive("mw_run",    C_RW,  0, 0, 0, MST);
    drive("mw_w0",     C_RW,  0, 0, 0, MST);
    drive("mw_w1",     C_RW,  0, 0, 0, MST);
    drive("mw_rel",    C_RR,  0, 0, 0, MREL);
    drive("mw_done",   C_IDL, 0, 0, 0, NONE);
    drive("zero_wait", C_RR,  0, 0, 0, MREL);
    drive("zw_done",   C_IDL, 0, 0, 0, NONE);
    // timeout: 4 stall cycles then abort
    drive("to_run",    C_WW,  0, 0, 0, MST);
    drive("to_w0",     C_WW,  0, 0, 0, MST);
    drive("to_w1",     C_WW,  0, 0, 0, MST);
    drive("to_w2",     C_WW,  0, 0, 0, MST);
    drive("to_abort",  C_WW,  0, 0, 0, ABRT);
    drive("err_stky1", C_IDL, 0, 0, 0, NONE);
    drive("err_stky2", C_IDL, 0, 0, 0, NONE);
    // wait + branch + load-use together
    drive("col_run",   C_COL, 5, 0, 5, MST);
    drive("col_w0",    C_COL, 5, 0, 5, MST);
    drive("col_rel",   C_COR, 5, 0, 5, MRELB);
    drive("col_done",  C_IDL, 0, 0, 0, NONE);
    // reset in the middle of a wait
    drive("rw_run",    C_RW,  0, 0, 0, MST);
    drive("rw_w0",     C_RW,  0, 0, 0, MST);
    drive("rw_rst",    C_RST, 0, 0, 0, NONE);
    drive("rw_after",  C_IDL, 0, 0, 0, NONE);
    drive("rw_zw",     C_RR,  0, 0, 0, MREL);
    drive("rw_end",    C_IDL, 0, 0, 0, NONE);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It watches the ID/EX and EX/MEM pipeline-register outputs and the data-memory ready line, then drives hold and bubble controls into PC, IF/ID, ID/EX and EX/MEM. It handles three cases: load-use hazards, taken-branch flushes, and variable-latency data-memory waits, with a timeout. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- TIMEOUT, 16: maximum MEM_WAIT cycles before abort; legal range 2..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Mem_Read_ID_EX  in  1  the instruction in EX is a load.
- rd_ID_EX  in  5  destination register of the instruction in EX.
- rs1_IF_ID, rs2_IF_ID  in  5 each  source registers of the instruction in ID.
- Mem_Read_EX_MEM, Mem_Write_EX_MEM  in  1 each  the instruction in MEM accesses memory.
- PcSrc_EX_MEM  in  1  the branch in MEM is taken.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request strobe.
- stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM  out  1 each  hold the register's contents.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load a bubble (all controls 0) into the register.
- mem_abort  out  1  one-cycle pulse when a timeout releases the pipeline.
- mem_err  out  1  sticky flag, set on timeout.
- cnt_stall, cnt_flush  out  CNT_W  saturating event counters.

## Operation
- State machine with two states: RUN (reset state) and MEM_WAIT.
- mem_op = Mem_Read_EX_MEM | Mem_Write_EX_MEM.
- dmem_req = mem_op in either state.
- busy = mem_op & ~dmem_ready & ~timeout_hit. timeout_hit is true in MEM_WAIT when wait_cnt == TIMEOUT-1.
- Priority 1, memory wait (busy=1):
  - Assert stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM.
  - Assert no flush.
  - RUN goes to MEM_WAIT, with wait_cnt cleared to 0.
  - MEM_WAIT stays in MEM_WAIT, wait_cnt increments.
- Completion:
  - In MEM_WAIT, dmem_ready=1 releases all stalls the same cycle; next state is RUN.
  - timeout_hit with ~dmem_ready also releases all stalls the same cycle. It pulses mem_abort, sets mem_err, and next state is RUN.
- Priority 2, taken branch (PcSrc_EX_MEM, not busy):
  - Assert flush_IF_ID, flush_ID_EX and flush_EX_MEM.
  - No stalls; the PC loads the branch target.
- Priority 3, load-use (not busy, no branch):
  - Condition: Mem_Read_ID_EX, rd_ID_EX != 0, and rd_ID_EX equals rs1_IF_ID or rs2_IF_ID.
  - Assert stall_PC and stall_IF_ID, plus flush_ID_EX.
- Whenever a stall asserts, the same register's flush never asserts.
- mem_err clears only on rst.
- cnt_stall increments every cycle that stall_PC=1. cnt_flush increments every cycle that flush_IF_ID=1. Both saturate at all-ones and never wrap.

## Timing
- All stall, flush and dmem_req outputs are combinational from the current state and inputs, so they take effect at the next clock edge. mem_abort is also combinational (timeout_hit & ~dmem_ready).
- State, wait_cnt, mem_err and the counters are registered.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, cnt_stall=0, cnt_flush=0. With all inputs low, every output is 0.
- rst asserted mid-MEM_WAIT returns to RUN the next edge; no abort or error results.
- Zero-wait memory (dmem_ready=1 when mem_op first rises) adds no stall cycles and never enters MEM_WAIT.
- Maximum stall per access is TIMEOUT cycles. Stall asserts in RUN plus MEM_WAIT at wait_cnt = 0..TIMEOUT-2; release comes at wait_cnt = TIMEOUT-1.
- A branch and a load-use in the same cycle: the branch wins, and the load in EX is flushed anyway.
- busy together with a branch: the stall wins, and the branch flush applies on the release cycle. PcSrc_EX_MEM is held by stall_EX_MEM.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN, MEM_WAIT);
  - the 5-bit register-index type and the x0 constant;
  - the default TIMEOUT.
- One natural sub-module, sat_counter: a parameterised-width saturating incrementer with enable. It is instantiated twice, for cnt_stall and cnt_flush.

## Test plan
- Load-use: set Mem_Read_ID_EX=1, rd_ID_EX=5, rs2_IF_ID=5 for one cycle. Require stall_PC=stall_IF_ID=flush_ID_EX=1 that cycle and cnt_stall=1 afterwards. Repeat with rd_ID_EX=0: no stall.
- Branch: set PcSrc_EX_MEM=1 for one cycle. Require all three flushes =1 and no stalls, and cnt_flush increments by 1.
- Memory wait: set Mem_Read_EX_MEM=1 with dmem_ready low for 3 cycles, then high. Require 3 stall cycles with all four stalls asserted, release on the 4th cycle, and the state back in RUN.
- Timeout: use TIMEOUT=4 with Mem_Write_EX_MEM=1 and dmem_ready held low. Require stalls for 4 cycles, a mem_abort pulse on the 5th cycle, and mem_err=1 sticky until rst.
- Collision: assert busy together with PcSrc_EX_MEM and a load-use match. Require only stalls until dmem_ready, then flushes on the release cycle.
- Reset mid-wait and saturation: assert rst in MEM_WAIT and require all outputs 0 next cycle. Use CNT_W=2 with 5 stalls and require cnt_stall=3.
